// File: rtl/cndm_core_ctrl_regs.sv
// cndm_core_ctrl_regs
// Core-level control register block (AXI-lite slot 0) for the Corundum-micro
// datapath: firmware ID/version, scratch, port-window layout, and a per-port
// interrupt controller with W1C pending, enable, force and holdoff-based
// moderation driven by a shared prescaled tick.
//
// Handshake semantics (AXI-lite, one outstanding transaction per direction):
//   write: accepted on a cycle where awvalid && wvalid && !bvalid. On that edge
//          the register is updated, awready/wready pulse for exactly one cycle
//          and bvalid rises; bvalid then holds until bready is seen high.
//   read:  accepted on a cycle where arvalid && !rvalid. On that edge arready
//          pulses for one cycle and rvalid/rdata are registered; rvalid and
//          rdata hold until rready is seen high.
//   bresp and rresp are always OKAY (0). wstrb is ignored (full-word writes).
module cndm_core_ctrl_regs #(
  parameter int          PORTS       = 2,
  parameter logic [31:0] PORT_OFFSET = 32'h00020000,
  parameter logic [31:0] PORT_STRIDE = 32'h00010000,
  parameter logic [31:0] FW_ID       = 32'h00000000,
  parameter logic [31:0] FW_VER      = 32'h00000000,
  parameter int          IRQ_TIMER_W = 16,
  parameter int          PRESCALE    = 250
) (
  input  logic             clk,
  input  logic             rst,

  input  logic [15:0]      s_axil_awaddr,
  input  logic [2:0]       s_axil_awprot,
  input  logic             s_axil_awvalid,
  output logic             s_axil_awready,
  input  logic [31:0]      s_axil_wdata,
  input  logic [3:0]       s_axil_wstrb,
  input  logic             s_axil_wvalid,
  output logic             s_axil_wready,
  output logic [1:0]       s_axil_bresp,
  output logic             s_axil_bvalid,
  input  logic             s_axil_bready,

  input  logic [15:0]      s_axil_araddr,
  input  logic [2:0]       s_axil_arprot,
  input  logic             s_axil_arvalid,
  output logic             s_axil_arready,
  output logic [31:0]      s_axil_rdata,
  output logic [1:0]       s_axil_rresp,
  output logic             s_axil_rvalid,
  input  logic             s_axil_rready,

  input  logic [PORTS-1:0] port_irq,
  output logic [PORTS-1:0] irq
);

  // Word addresses (byte address >> 2)
  localparam logic [13:0] ADDR_FW_ID      = 14'h0000;
  localparam logic [13:0] ADDR_FW_VER     = 14'h0001;
  localparam logic [13:0] ADDR_SCRATCH    = 14'h0002;
  localparam logic [13:0] ADDR_PORTS      = 14'h0040;
  localparam logic [13:0] ADDR_PORT_OFF   = 14'h0041;
  localparam logic [13:0] ADDR_PORT_STR   = 14'h0042;
  localparam logic [13:0] ADDR_IRQ_PEND   = 14'h0080;
  localparam logic [13:0] ADDR_IRQ_EN     = 14'h0081;
  localparam logic [13:0] ADDR_IRQ_INTV   = 14'h0082;
  localparam logic [13:0] ADDR_IRQ_FORCE  = 14'h0083;

  // A prescale of 1 still needs a 1-bit counter that never leaves 0.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [13:0]            wr_addr;
  logic [13:0]            rd_addr;
  logic                   wr_en;
  logic                   rd_en;
  logic [PORTS-1:0]       wdata_ports;

  logic                   wr_pend;
  logic                   wr_force;

  logic [31:0]            scratch;
  logic [PORTS-1:0]       pending;
  logic [PORTS-1:0]       enable;
  logic [IRQ_TIMER_W-1:0] interval;
  logic [IRQ_TIMER_W-1:0] holdoff [PORTS];

  logic [PS_W-1:0]        ps_cnt;
  logic                   tick;

  logic [PORTS-1:0]       deliver;
  logic [PORTS-1:0]       irq_set;
  logic [PORTS-1:0]       irq_clr;
  logic [PORTS-1:0]       pending_next;

  logic [31:0]            pend_word;
  logic [31:0]            en_word;
  logic [31:0]            intv_word;
  logic [31:0]            rd_data;

  // Protection bits, byte strobes and sub-word address bits carry no meaning here.
  logic                   unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_wstrb,
                       s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  assign wr_addr     = s_axil_awaddr[15:2];
  assign rd_addr     = s_axil_araddr[15:2];
  assign wr_en       = s_axil_awvalid && s_axil_wvalid && !s_axil_bvalid;
  assign rd_en       = s_axil_arvalid && !s_axil_rvalid;
  assign wdata_ports = s_axil_wdata[PORTS-1:0];

  assign wr_pend     = wr_en && (wr_addr == ADDR_IRQ_PEND);
  assign wr_force    = wr_en && (wr_addr == ADDR_IRQ_FORCE);

  assign s_axil_bresp = 2'b00;
  assign s_axil_rresp = 2'b00;

  // Write channel: one-cycle ready pulse, response held until bready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
    end else begin
      s_axil_awready <= wr_en;
      s_axil_wready  <= wr_en;
      if (wr_en) begin
        s_axil_bvalid <= 1'b1;
      end else if (s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
    end
  end

  // Plain RW registers written on write acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scratch  <= '0;
      enable   <= '0;
      interval <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_SCRATCH:  scratch  <= s_axil_wdata;
        ADDR_IRQ_EN:   enable   <= wdata_ports;
        ADDR_IRQ_INTV: interval <= s_axil_wdata[IRQ_TIMER_W-1:0];
        default: ;
      endcase
    end
  end

  // Zero-extend the narrow registers to the 32-bit data bus.
  always_comb begin
    pend_word = '0;
    en_word   = '0;
    intv_word = '0;
    pend_word[PORTS-1:0]       = pending;
    en_word[PORTS-1:0]         = enable;
    intv_word[IRQ_TIMER_W-1:0] = interval;
  end

  // Read decode; unmapped and write-only locations return 0.
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_FW_ID:    rd_data = FW_ID;
      ADDR_FW_VER:   rd_data = FW_VER;
      ADDR_SCRATCH:  rd_data = scratch;
      ADDR_PORTS:    rd_data = 32'(PORTS);
      ADDR_PORT_OFF: rd_data = PORT_OFFSET;
      ADDR_PORT_STR: rd_data = PORT_STRIDE;
      ADDR_IRQ_PEND: rd_data = pend_word;
      ADDR_IRQ_EN:   rd_data = en_word;
      ADDR_IRQ_INTV: rd_data = intv_word;
      default:       rd_data = '0;
    endcase
  end

  // Read channel: one-cycle arready pulse, data held until rready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rdata   <= '0;
    end else begin
      s_axil_arready <= rd_en;
      if (rd_en) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rdata  <= rd_data;
      end else if (s_axil_rready) begin
        s_axil_rvalid <= 1'b0;
      end
    end
  end

  // Free-running moderation prescaler; tick marks the wrap cycle.
  assign tick = (ps_cnt == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_cnt <= '0;
    end else if (tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  // Delivery and pending update; a set always wins over a clear so no
  // event arriving on the same edge as a W1C or a delivery is lost.
  always_comb begin
    deliver = '0;
    for (int p = 0; p < PORTS; p++) begin
      deliver[p] = pending[p] && enable[p] && (holdoff[p] == '0);
    end
    irq_set      = port_irq | (wr_force ? wdata_ports : '0);
    irq_clr      = deliver  | (wr_pend  ? wdata_ports : '0);
    pending_next = irq_set | (pending & ~irq_clr);
  end

  // Pending bits and the registered one-cycle interrupt pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      irq     <= '0;
    end else begin
      pending <= pending_next;
      irq     <= deliver;
    end
  end

  // Holdoff counters: reload with the current interval on delivery, then
  // count down one per tick, stopping at 0. Later interval writes only
  // affect the next reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < PORTS; p++) begin
        holdoff[p] <= '0;
      end
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        if (deliver[p]) begin
          holdoff[p] <= interval;
        end else if (tick && (holdoff[p] != '0)) begin
          holdoff[p] <= holdoff[p] - IRQ_TIMER_W'(1);
        end
      end
    end
  end

endmodule
